counter_run_controller: RTL
===========================

# counter_run_controller

Sequencing controller for the front-panel up/down counter. It conditions the raw push-buttons and direction switch, generates the count-rate tick, and runs a run/pause/alarm state machine. Its outputs are single-cycle strobes and levels: enable, direction, load, clear and buzzer. The counter datapath keeps the count; this block decides when it moves.

## Interface
Parameters:
- DIV, 50_000_000 — Clk cycles per count tick; must be ≥ 2.
- DEB_CYCLES, 1_000_000 — consecutive stable cycles required to accept a button or switch level; must be ≥ 1.
- BUZ_TICKS, 3 — buzzer duration in count ticks after a wrap; must be ≥ 1.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_start, btn_stop, btn_load, btn_clear  in  1 each  raw asynchronous push-buttons, active-high.
- mode_up  in  1  raw direction switch; 1 = up, 0 = down.
- wrap  in  1  one-cycle pulse from the counter when it wraps (99→0 up, 0→99 down).
- tick_en  out  1  one-cycle count enable.
- count_up  out  1  direction to counter, held level.
- load_req  out  1  one-cycle preset-load strobe.
- clear_req  out  1  one-cycle clear strobe.
- buz  out  1  buzzer drive.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, ALARM=11.

## Operation
- Input conditioning, applied to each of the four buttons and mode_up:
  - 2-FF synchronizer.
  - Debouncer: the accepted level changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles. Any glitch restarts the count.
  - Each button's accepted level is rising-edge detected into a one-cycle event: start_ev, stop_ev, load_ev, clear_ev.
- Prescaler counter, 0..DIV-1:
  - Increments in RUN and ALARM.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE.
  - Internal tick = prescaler at DIV-1, after which it returns to 0.
- Event priority within a cycle: clear_ev > stop_ev > wrap > start_ev > load_ev. Only the highest-priority applicable event acts; the others are dropped, not queued.
- State transitions:
  - IDLE: start_ev → RUN. load_ev → load_req pulse, stay in IDLE. clear_ev → clear_req pulse.
  - RUN: tick_en = internal tick. stop_ev → PAUSE. wrap → ALARM with buz=1 and the buzzer tick counter set to 0. clear_ev → IDLE with clear_req. load_ev is ignored.
  - PAUSE: start_ev → RUN; the prescaler resumes from its held value. load_ev → load_req. clear_ev → IDLE with clear_req.
  - ALARM:
    - Counting continues: tick_en = internal tick.
    - Each internal tick increments the buzzer tick counter. On the BUZ_TICKS-th tick, buz drops and the state returns to RUN.
    - stop_ev → PAUSE with buz=0.
    - clear_ev → IDLE with buz=0 and clear_req.
    - A further wrap in ALARM restarts the buzzer count at 0.
- Direction: count_up takes the debounced mode_up only in IDLE or PAUSE. It is frozen in RUN and ALARM.
- All outputs are registered.

## Timing
- Reset values: state=IDLE, tick_en=0, load_req=0, clear_req=0, buz=0, count_up=1, prescaler=0, debounced levels=0.
- A reset mid-operation takes effect immediately, asynchronously, in any state.
- Button latency: a raw press held stable produces its event DEB_CYCLES+3 cycles after the first high sample (2 sync + DEB_CYCLES + 1 edge). The resulting output strobe appears one cycle later.
- Release produces no event. A held button produces exactly one event.
- tick_en period is exactly DIV cycles in RUN. The first tick after RUN entry from IDLE arrives DIV cycles after the transition edge.
- wrap arriving in the same cycle as stop_ev: go to PAUSE with buz=0; the wrap is lost. wrap in IDLE or PAUSE is ignored.
- tick_en, load_req and clear_req are never high for two consecutive cycles. load_req and clear_req are never high together.

## Test plan
Bench parameters: DIV=4, DEB_CYCLES=3, BUZ_TICKS=2.
- Reset, then press btn_start for 10 cycles → state=01 at cycle 7 after the press. tick_en then pulses every 4 cycles, first pulse 4 cycles after the state change. count_up=1.
- In RUN, a 2-cycle btn_stop glitch → no change. A 10-cycle btn_stop → state=10 and tick_en stops. Prescaler holds; on btn_start, the first tick arrives after the remaining 4-N cycles.
- In RUN, pulse wrap → state=11, buz=1 for exactly 2 ticks (8 cycles) with tick_en still pulsing, then state=01 and buz=0. Repeat with stop_ev coincident with wrap → state=10, buz stays 0.
- IDLE/PAUSE: btn_load → one load_req pulse. In RUN, btn_load → no load_req. btn_clear in RUN, PAUSE and ALARM → one clear_req pulse, state=00, buz=0, prescaler=0.
- Flip mode_up to 0 during RUN → count_up stays 1. After stop → count_up=0 within 1 cycle of the debounced change in PAUSE.
- Assert reset while in ALARM → all outputs return to their reset values asynchronously, with no pulses afterwards until a new start.

Source files
------------

// File: rtl/counter_run_controller.sv
// Front-panel counter sequencer: button conditioning, rate prescaler
// and run/pause/alarm control for the up/down counter datapath.
module counter_run_controller #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BUZ_TICKS  = 3
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_load,
  input  logic       btn_clear,
  input  logic       mode_up,
  input  logic       wrap,
  output logic       tick_en,
  output logic       count_up,
  output logic       load_req,
  output logic       clear_req,
  output logic       buz,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BUZ_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  state_t          st;
  logic [4:0]      raw;
  logic [4:0]      s1;
  logic [4:0]      s2;
  logic [4:0]      lvl;
  logic [3:0]      lvl_d;
  logic [3:0]      ev;
  logic [DW-1:0]   dcnt [5];
  logic [PW-1:0]   pre;
  logic [BW-1:0]   bcnt;
  logic            tick;
  logic            run_like;
  logic            start_ev;
  logic            stop_ev;
  logic            load_ev;
  logic            clear_ev;

  assign raw = {mode_up, btn_clear, btn_load,
                btn_stop, btn_start};

  assign start_ev = ev[0];
  assign stop_ev  = ev[1];
  assign load_ev  = ev[2];
  assign clear_ev = ev[3];

  assign tick     = (pre == PW'(DIV - 1));
  assign run_like = (st == RUN) || (st == ALARM);
  assign state    = st;

  // Level accepted only after DEB_CYCLES unbroken disagreeing samples.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      ev    <= '0;
      for (int i = 0; i < 5; i++)
        dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl[3:0];
      ev    <= lvl[3:0] & ~lvl_d;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          dcnt[i] <= '0;
          lvl[i]  <= s2[i];
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clear_ev || st == IDLE) begin
      pre <= '0;
    end else if (run_like) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      tick_en   <= 1'b0;
      load_req  <= 1'b0;
      clear_req <= 1'b0;
      buz       <= 1'b0;
      count_up  <= 1'b1;
      bcnt      <= '0;
    end else begin
      tick_en   <= run_like & tick & ~clear_ev;
      load_req  <= 1'b0;
      clear_req <= 1'b0;
      if (st == IDLE || st == PAUSE)
        count_up <= lvl[4];
      unique case (st)
        IDLE: begin
          if (clear_ev)
            clear_req <= 1'b1;
          else if (start_ev)
            st <= RUN;
          else if (load_ev)
            load_req <= 1'b1;
        end
        RUN: begin
          if (clear_ev) begin
            st        <= IDLE;
            clear_req <= 1'b1;
          end else if (stop_ev) begin
            st <= PAUSE;
          end else if (wrap) begin
            st   <= ALARM;
            buz  <= 1'b1;
            bcnt <= '0;
          end
        end
        PAUSE: begin
          if (clear_ev) begin
            st        <= IDLE;
            clear_req <= 1'b1;
          end else if (start_ev) begin
            st <= RUN;
          end else if (load_ev) begin
            load_req <= 1'b1;
          end
        end
        ALARM: begin
          if (clear_ev) begin
            st        <= IDLE;
            buz       <= 1'b0;
            clear_req <= 1'b1;
          end else if (stop_ev) begin
            st  <= PAUSE;
            buz <= 1'b0;
          end else if (wrap) begin
            bcnt <= '0;
          end else if (tick) begin
            if (bcnt == BW'(BUZ_TICKS - 1)) begin
              st   <= RUN;
              buz  <= 1'b0;
              bcnt <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
